buzzer_sched: RTL and testbench
===============================

Name: buzzer_sched

Overview:
- Scheduler that shares the single buzzer tune player (work_en/end_note interface) among three vending-FSM event sources: sale complete, refund/change, key click.
- Latches request pulses, arbitrates by fixed priority, drives the player's 2-bit song select, enforces an inter-song silence gap, and aborts hung playback with a watchdog.
- Sits between the vending FSM and the buzzer tune player.

Parameters:
- BEEP_CYCLES, 5_000_000, length of a key click in clk cycles (100 ms at 50 MHz); song 1 truncated.
- GAP_CYCLES, 2_500_000, forced work_en==0 silence after every playback (player counters clear).
- TIMEOUT_CYCLES, 750_000_000, watchdog limit for one song playback (15 s).
- CNT_W, 30, width of the shared cycle counter; must hold max of the three above.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req_sold  in  1  one-cycle pulse: play song 1 (sale tune)
- req_refund  in  1  one-cycle pulse: play song 2 (refund tune)
- req_key  in  1  one-cycle pulse: key click
- mute  in  1  level: silence and discard everything
- end_note  in  1  one-cycle pulse from player: last note of song finished
- work_en  out  2  song select to player: 0 off, 1 song 1, 2 song 2
- busy  out  1  high in PLAY or GAP
- cur_src  out  2  granted source: 0 none, 1 sold, 2 refund, 3 key
- timeout  out  1  one-cycle pulse when watchdog aborts a playback

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-high.
- Reset: state IDLE, pend[2:0]=0, cnt=0, work_en=0, busy=0, cur_src=0, timeout=0. Reset mid-playback silences work_en immediately (asynchronous).
- Pending flags: pend[x] set on req_x pulse; cleared only on the edge where x is granted. Repeated pulses while pending merge (no queue depth). A request for the currently playing source sets pend again -> replay after GAP.
- Priority: sold > refund > key, evaluated over (pend | req) so a pulse in IDLE is granted on the same edge.
- States (all outputs registered):
  - IDLE: work_en=0, busy=0, cur_src=0. If any (pend|req) and !mute -> PLAY; cnt=0; cur_src=winner; work_en=1 (sold), 2 (refund), 1 (key). Latency: req pulse at edge k -> work_en valid after edge k.
  - PLAY: cnt increments each cycle. Exit to GAP (work_en=0, cnt=0) on first of:
    - end_note with cur_src sold/refund;
    - cur_src key and cnt==BEEP_CYCLES-1 (end_note ignored for key);
    - cnt==TIMEOUT_CYCLES-1 with no end_note -> timeout pulses 1 cycle.
  - Simultaneous end_note and watchdog terminal: end_note wins, no timeout pulse.
  - GAP: work_en=0, busy=1, cur_src=0; cnt increments; at cnt==GAP_CYCLES-1 -> IDLE, cnt=0. Requests arriving here only set pend.
- mute high: on next edge pend cleared, state -> IDLE, work_en=0, cnt=0, no timeout; requests ignored while mute high.
- cnt saturates never; it is always cleared on state change, no wrap within a state given parameter constraint.

Optional Feature:
- Macro BUZZER_PREEMPT_EN.
- Defined: in PLAY, a (pend|req) of strictly higher priority than cur_src aborts current playback -> GAP (preempted source not re-queued); preempted start counts as normal grant after GAP.
- Undefined: no preemption; higher-priority requests wait in pend until IDLE.

Test Plan (BEEP_CYCLES=10, GAP_CYCLES=4, TIMEOUT_CYCLES=100, CNT_W=8):
- rst released, req_sold pulse -> work_en=1, cur_src=1 next cycle; end_note 50 cycles later -> work_en=0 next cycle, busy high 4 more cycles, then busy=0.
- req_key and req_refund same cycle in IDLE -> refund plays (work_en=2); end_note -> 4-cycle gap -> key click: work_en=1 exactly 10 cycles, cur_src=3.
- req_sold, no end_note -> work_en=1 for 100 cycles, timeout pulse once, GAP 4 cycles, IDLE.
- end_note on same cycle as cnt==99 -> no timeout pulse, normal GAP.
- Mute asserted mid-song with pend[2] set -> work_en=0 next edge, pend cleared; after mute release no playback occurs.
- Undefined BUZZER_PREEMPT_EN: req_sold during key click -> click completes 10 cycles, gap, then sold. Defined: next edge work_en=0, GAP, then work_en=1 cur_src=1; rst pulse mid-sold -> all outputs 0 immediately.

Source files
------------

// File: rtl/buzzer_sched.sv
// buzzer_sched: shares one tune player among sale/refund/key events; fixed priority, gap, watchdog, mute.
// Grant visible one edge after a request; requests merge in pend (no depth). Option: BUZZER_PREEMPT_EN.
module buzzer_sched #(
  parameter int BEEP_CYCLES    = 5_000_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter int TIMEOUT_CYCLES = 750_000_000,
  parameter int CNT_W          = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_sold,
  input  logic       req_refund,
  input  logic       req_key,
  input  logic       mute,
  input  logic       end_note,
  output logic [1:0] work_en,
  output logic       busy,
  output logic [1:0] cur_src,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_SOLD   = 2'd1;
  localparam logic [1:0] SRC_REFUND = 2'd2;
  localparam logic [1:0] SRC_KEY    = 2'd3;

  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [2:0]       pend;
  logic [2:0]       cand;
  logic [2:0]       win_oh;
  logic [1:0]       win_src;
  logic [CNT_W-1:0] cnt;
  logic             song_done;
  logic             preempt;

  // bit 0 sold, bit 1 refund, bit 2 key; a same-cycle pulse competes with stored ones
  assign cand = pend | {req_key, req_refund, req_sold};

  always_comb begin
    win_src = SRC_NONE;
    win_oh  = 3'b000;
    if (cand[0]) begin
      win_src = SRC_SOLD;
      win_oh  = 3'b001;
    end else if (cand[1]) begin
      win_src = SRC_REFUND;
      win_oh  = 3'b010;
    end else if (cand[2]) begin
      win_src = SRC_KEY;
      win_oh  = 3'b100;
    end
  end

  // Key clicks have no tune, so they end on the beep length and never on end_note
  assign song_done = (end_note && ((cur_src == SRC_SOLD) || (cur_src == SRC_REFUND))) ||
                     ((cur_src == SRC_KEY) && (cnt == BEEP_LAST));

`ifdef BUZZER_PREEMPT_EN
  // Lower source code means higher priority; the winner stays pending and is granted after the gap
  assign preempt = (win_src != SRC_NONE) && (win_src < cur_src);
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= 3'b000;
      cnt     <= '0;
      work_en <= 2'd0;
      busy    <= 1'b0;
      cur_src <= SRC_NONE;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (mute) begin
        state   <= IDLE;
        pend    <= 3'b000;
        cnt     <= '0;
        work_en <= 2'd0;
        busy    <= 1'b0;
        cur_src <= SRC_NONE;
      end else begin
        case (state)
          IDLE: begin
            if (win_src != SRC_NONE) begin
              state   <= PLAY;
              pend    <= cand & ~win_oh;
              cnt     <= '0;
              cur_src <= win_src;
              work_en <= (win_src == SRC_REFUND) ? 2'd2 : 2'd1;
              busy    <= 1'b1;
            end else begin
              pend <= cand;
            end
          end
          PLAY: begin
            pend <= cand;
            if (song_done || preempt || (cnt == TMO_LAST)) begin
              // a normal finish on the watchdog's last cycle is not a timeout
              timeout <= !(song_done || preempt);
              state   <= GAP;
              cnt     <= '0;
              work_en <= 2'd0;
              cur_src <= SRC_NONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            pend <= cand;
            if (cnt == GAP_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            work_en <= 2'd0;
            busy    <= 1'b0;
            cur_src <= SRC_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_sched.sv
// Scoreboard bench for buzzer_sched: a timestamp-based playback model predicts each playback record,
// a negedge monitor reconstructs records from the DUT outputs and compares them.
module tb_buzzer_sched;

  localparam int BEEP = 10;
  localparam int GAPC = 4;
  localparam int TMO  = 100;
  localparam int CW   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_sold = 1'b0, req_refund = 1'b0, req_key = 1'b0;
  logic       mute = 1'b0, end_note = 1'b0;
  logic [1:0] work_en, cur_src;
  logic       busy, timeout;

  buzzer_sched #(
    .BEEP_CYCLES(BEEP), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req_sold(req_sold), .req_refund(req_refund), .req_key(req_key),
    .mute(mute), .end_note(end_note), .work_en(work_en), .busy(busy), .cur_src(cur_src),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;  // cycle number of first audible cycle
    int src;
    int wen;
    int len;    // audible cycles
    int tmo;    // watchdog fired at the end
    int gap;    // busy-only cycles after the sound
  } play_t;

  play_t exp_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0;
  bit    sb_on = 1'b1;

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // ---------------- reference model: playback timeline by timestamps ----------------
  int         m_mode = 0;  // 0 quiet, 1 sounding, 2 silence gap
  logic [2:0] m_pend = 3'b000;
  play_t      m_rec;
  int         m_gap_start = 0;
  int         m_tmo_cnt = 0;

  function automatic int winner(input logic [2:0] w);
    for (int i = 0; i < 3; i++) if (w[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [2:0] want;
    int w, played;
    bit done;
    cyc++;
    if (rst) begin
      m_mode = 0;
      m_pend = 3'b000;
      return;
    end
    if (mute) begin
      if (m_mode == 1) begin
        m_rec.len = cyc - m_rec.start;
        m_rec.tmo = 0;
        m_rec.gap = 0;
        exp_q.push_back(m_rec);
      end else if (m_mode == 2) begin
        m_rec.gap = cyc - m_gap_start;
        exp_q.push_back(m_rec);
      end
      m_mode = 0;
      m_pend = 3'b000;
      return;
    end
    want   = m_pend | {req_key, req_refund, req_sold};
    w      = winner(want);
    m_pend = want;
    case (m_mode)
      0: if (w >= 0) begin
        m_mode      = 1;
        m_pend[w]   = 1'b0;
        m_rec.start = cyc;
        m_rec.src   = w + 1;
        m_rec.wen   = (w == 1) ? 2 : 1;
        m_rec.tmo   = 0;
      end
      1: begin
        played = cyc - m_rec.start;
        done = (m_rec.src != 3 && end_note) || (m_rec.src == 3 && played == BEEP);
`ifdef BUZZER_PREEMPT_EN
        if (w >= 0 && (w + 1) < m_rec.src) done = 1'b1;
`endif
        if (done || played == TMO) begin
          m_rec.len   = played;
          m_rec.tmo   = done ? 0 : 1;
          m_tmo_cnt  += m_rec.tmo;
          m_mode      = 2;
          m_gap_start = cyc;
        end
      end
      default: if (cyc - m_gap_start == GAPC) begin
        m_rec.gap = GAPC;
        exp_q.push_back(m_rec);
        m_mode = 0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  int    mn_state = 0;
  int    mn_tmo_cnt = 0;
  play_t got;
  bit    mn_bad = 1'b0;

  task automatic mon_finish();
    play_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_playback: src %0d start %0d len %0d, expected none", got.src, got.start, got.len);
      return;
    end
    e = exp_q.pop_front();
    chk("start_cycle", got.start, e.start);
    chk("cur_src", got.src, e.src);
    chk("work_en", got.wen, e.wen);
    chk("sound_len", got.len, e.len);
    chk("timeout_pulse", got.tmo, e.tmo);
    chk("gap_len", got.gap, e.gap);
    chk("outputs_consistent", int'(mn_bad), 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (!sb_on) begin
      mn_state = 0;
    end else begin
      if (timeout) mn_tmo_cnt++;
      case (mn_state)
        0: if (work_en != 2'd0) begin
          got.start = cyc;
          got.src   = int'(cur_src);
          got.wen   = int'(work_en);
          got.len   = 1;
          got.tmo   = 0;
          got.gap   = 0;
          mn_bad    = !busy;
          mn_state  = 1;
        end
        1: if (work_en != 2'd0) begin
          got.len++;
          if (int'(cur_src) != got.src || int'(work_en) != got.wen || !busy) mn_bad = 1'b1;
        end else begin
          got.tmo = int'(timeout);
          if (busy) begin
            got.gap = 1;
            if (cur_src != 2'd0) mn_bad = 1'b1;
            mn_state = 2;
          end else begin
            mon_finish();
            mn_state = 0;
          end
        end
        default: if (busy && work_en == 2'd0) begin
          got.gap++;
          if (cur_src != 2'd0) mn_bad = 1'b1;
        end else begin
          mon_finish();
          mn_state = 0;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input int which);
    @(negedge clk);
    req_sold   = (which == 0);
    req_refund = (which == 1);
    req_key    = (which == 2);
    @(negedge clk);
    req_sold = 1'b0; req_refund = 1'b0; req_key = 1'b0;
  endtask

  // called right after pulse(): end_note lands on the edge where n cycles have sounded
  task automatic end_at(input int n);
    repeat (n - 1) @(negedge clk);
    end_note = 1'b1;
    @(negedge clk);
    end_note = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(m_mode == 0 && m_pend == 3'b000 && mn_state == 0 && !busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", int'(n < 1000), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_work_en", int'(work_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cur_src", int'(cur_src), 0);
    chk("reset_timeout", int'(timeout), 0);
    rst = 1'b0;

    pulse(0); end_at(50); wait_idle();             // sale tune, end_note after 50
    @(negedge clk); req_key = 1'b1; req_refund = 1'b1;
    @(negedge clk); req_key = 1'b0; req_refund = 1'b0;
    end_at(20); wait_idle();                       // refund first, then the click
    pulse(0); wait_idle();                         // no end_note: watchdog
    pulse(0); end_at(TMO); wait_idle();            // end_note on the watchdog's last cycle
    pulse(0); repeat (4) @(negedge clk); pulse(2); // key pending mid-song
    repeat (3) @(negedge clk); mute = 1'b1;
    repeat (3) @(negedge clk); mute = 1'b0;
    repeat (20) @(negedge clk);
    chk("after_mute_work_en", int'(work_en), 0);
    chk("after_mute_busy", int'(busy), 0);
    wait_idle();
    pulse(2); repeat (2) @(negedge clk); pulse(0); wait_idle();  // sale during click

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      req_sold   = ($urandom_range(39) == 0);
      req_refund = ($urandom_range(39) == 0);
      req_key    = ($urandom_range(29) == 0);
      end_note   = ($urandom_range(24) == 0);
      if (mute) mute = ($urandom_range(3) != 0);
      else      mute = ($urandom_range(299) == 0);
    end
    @(negedge clk);
    req_sold = 1'b0; req_refund = 1'b0; req_key = 1'b0; end_note = 1'b0; mute = 1'b0;
    wait_idle();
    chk("leftover_expected", exp_q.size(), 0);
    chk("timeout_pulse_count", mn_tmo_cnt, m_tmo_cnt);

    pulse(0); repeat (5) @(negedge clk);
    sb_on = 1'b0;
    chk("pre_reset_work_en", int'(work_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_work_en", int'(work_en), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_cur_src", int'(cur_src), 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_time_limit: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
